requant_writeback_packer: RTL and testbench

Receiving end of the requantizer output interface. Per-channel int8 results (valid/row/col/data, one lane per output channel) arrive independently and out of order across lanes. The block gathers all SA_N channel bytes for one output pixel into a single SA_N*8-bit word, computes its tensor-RAM word address, and writes it through a valid/ready RAM write port. It counts written pixels and signals layer completion.

---
 rtl/requant_writeback_packer_pkg.sv | 13 +
 rtl/wb_sync_fifo.sv | 67 ++++++
 rtl/requant_writeback_packer.sv | 219 +++++++++++++++++++++
 tb/tb_requant_writeback_packer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_writeback_packer_pkg.sv
// Shared types for the requantizer write-back packer.
// Holds the int8 lane type and the pass-control FSM encoding.
package requant_writeback_packer_pkg;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } wb_state_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO for completed {addr, data} words.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module wb_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/requant_writeback_packer.sv
// Gathers per-lane int8 requantizer results into packed pixel words and writes
// them to tensor RAM through a small completion FIFO.
module requant_writeback_packer
  import requant_writeback_packer_pkg::*;
#(
  parameter int unsigned SA_N       = 4,
  parameter int unsigned MAX_N      = 16,
  parameter int unsigned N_BITS     = $clog2(MAX_N),
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PEND_DEPTH = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cfg_valid,
  input  logic [ADDR_WIDTH-1:0]            cfg_base,
  input  logic [N_BITS:0]                  cfg_width,
  input  logic [7:0]                       cfg_groups,
  input  logic [7:0]                       cfg_group,
  input  logic [2*N_BITS:0]                cfg_num_pixels,
  input  logic [SA_N-1:0]                  in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]      in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]      in_col,
  input  int8_t [SA_N-1:0]                 in_data,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [SA_N*8-1:0]                wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow_err,
  output logic                             dup_err
);

  typedef logic [SA_N*8-1:0] wb_word_t;

  typedef struct packed {
    logic              valid;
    logic [N_BITS-1:0] row;
    logic [N_BITS-1:0] col;
    logic [SA_N-1:0]   mask;
    wb_word_t          bytes;
  } pend_entry_t;

  localparam int unsigned FifoW = ADDR_WIDTH + SA_N * 8;

  wb_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [N_BITS:0]    width_q, width_d;
  logic [7:0]         groups_q, groups_d, group_q, group_d;
  logic [2*N_BITS:0]  num_q, num_d, cnt_q, cnt_d;
  logic               ovf_q, ovf_d, dup_q, dup_d;
  pend_entry_t        tbl_q [PEND_DEPTH];
  pend_entry_t        tbl_d [PEND_DEPTH];

  logic               ovf_set, dup_set, lane_hit;
  logic               push_found, fifo_push, fifo_pop, fifo_full, fifo_empty;
  int                 push_idx;
  logic [N_BITS-1:0]  push_row, push_col;
  wb_word_t           push_bytes;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [FifoW-1:0]   fifo_dout;

  assign wr_valid     = !fifo_empty;
  assign fifo_pop     = wr_valid && wr_ready;
  assign {wr_addr, wr_data} = fifo_dout;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign overflow_err = ovf_q;
  assign dup_err      = dup_q;

  // Word address computed wide, then truncated to the RAM address width.
  assign push_addr = ADDR_WIDTH'(32'(base_q)
                     + (32'(push_row) * 32'(width_q) + 32'(push_col)) * 32'(groups_q)
                     + 32'(group_q));

  always_comb begin
    tbl_d      = tbl_q;
    ovf_set    = 1'b0;
    dup_set    = 1'b0;
    lane_hit   = 1'b0;
    push_found = 1'b0;
    push_idx   = 0;
    push_row   = '0;
    push_col   = '0;
    push_bytes = '0;

    // Eligibility comes from registered state, so a completing byte waits a cycle.
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (!push_found && tbl_q[i].valid && (&tbl_q[i].mask)) begin
        push_found = 1'b1;
        push_idx   = i;
        push_row   = tbl_q[i].row;
        push_col   = tbl_q[i].col;
        push_bytes = tbl_q[i].bytes;
      end
    end

    for (int ch = 0; ch < SA_N; ch++) begin
      if (in_valid[ch]) begin
        if (state_q != StActive) begin
          ovf_set = 1'b1;
        end else begin
          lane_hit = 1'b0;
          for (int i = 0; i < PEND_DEPTH; i++) begin
            if (!lane_hit && tbl_d[i].valid && tbl_d[i].row == in_row[ch]
                && tbl_d[i].col == in_col[ch]) begin
              lane_hit = 1'b1;
              dup_set  = dup_set | tbl_d[i].mask[ch];
              tbl_d[i].mask[ch] = 1'b1;
              tbl_d[i].bytes[8*ch +: 8] = in_data[ch];
            end
          end
          // Entry being pushed this cycle still reads valid, so it is not reused yet.
          for (int i = 0; i < PEND_DEPTH; i++) begin
            if (!lane_hit && !tbl_d[i].valid) begin
              lane_hit       = 1'b1;
              tbl_d[i].valid = 1'b1;
              tbl_d[i].row   = in_row[ch];
              tbl_d[i].col   = in_col[ch];
              tbl_d[i].mask  = '0;
              tbl_d[i].bytes = '0;
              tbl_d[i].mask[ch] = 1'b1;
              tbl_d[i].bytes[8*ch +: 8] = in_data[ch];
            end
          end
          if (!lane_hit) begin
            ovf_set = 1'b1;
          end
        end
      end
    end

    fifo_push = push_found && (!fifo_full || fifo_pop);
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (fifo_push && i == push_idx) begin
        tbl_d[i].valid = 1'b0;
        tbl_d[i].mask  = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    width_d  = width_q;
    groups_d = groups_q;
    group_d  = group_q;
    num_d    = num_q;
    cnt_d    = fifo_pop ? cnt_q + 1'b1 : cnt_q;
    ovf_d    = ovf_q | ovf_set;
    dup_d    = dup_q | dup_set;
    case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          state_d  = StActive;
          base_d   = cfg_base;
          width_d  = cfg_width;
          groups_d = cfg_groups;
          group_d  = cfg_group;
          num_d    = cfg_num_pixels;
          cnt_d    = '0;
          ovf_d    = ovf_set;
          dup_d    = 1'b0;
        end
      end
      StActive: begin
        if (num_q == '0 || (fifo_pop && cnt_d == num_q)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      width_q  <= '0;
      groups_q <= '0;
      group_q  <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      dup_q    <= 1'b0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      width_q  <= width_d;
      groups_q <= groups_d;
      group_q  <= group_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      dup_q    <= dup_d;
      tbl_q    <= tbl_d;
    end
  end

  wb_sync_fifo #(
    .Width(FifoW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (fifo_push),
    .data_i ({push_addr, push_bytes}),
    .pop_i  (fifo_pop),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_requant_writeback_packer.sv
// Bench for requant_writeback_packer: directed scenarios plus randomized passes
// checked against a per-pixel behavioural model.
module tb_requant_writeback_packer;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cfg_valid;
  logic [15:0]          cfg_base;
  logic [4:0]           cfg_width;
  logic [7:0]           cfg_groups, cfg_group;
  logic [8:0]           cfg_num_pixels;
  logic [3:0]           in_valid;
  logic [3:0][3:0]      in_row, in_col;
  logic [3:0][7:0]      in_data;
  logic                 wr_valid, wr_ready;
  logic [15:0]          wr_addr;
  logic [31:0]          wr_data;
  logic                 busy, done, overflow_err, dup_err;

  int  n_checks = 0;
  int  n_errs   = 0;
  int  done_cnt = 0;
  int  rdy_mode = 0;
  int  m_base, m_width, m_groups, m_group;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic hold_q = 1'b0;
  wr_t  hold_w;

  requant_writeback_packer u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_valid     (cfg_valid),
    .cfg_base      (cfg_base),
    .cfg_width     (cfg_width),
    .cfg_groups    (cfg_groups),
    .cfg_group     (cfg_group),
    .cfg_num_pixels(cfg_num_pixels),
    .in_valid      (in_valid),
    .in_row        (in_row),
    .in_col        (in_col),
    .in_data       (in_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .overflow_err  (overflow_err),
    .dup_err       (dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: collects handshakes and enforces hold-while-stalled.
  always @(negedge clk) begin
    if (reset_n && wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
    if (done) done_cnt <= done_cnt + 1;
    if (reset_n && hold_q) begin
      check("stall_valid", wr_valid, 1);
      check("stall_addr", wr_addr, hold_w.addr);
      check("stall_data", wr_data, hold_w.data);
    end
    hold_q <= reset_n && wr_valid && !wr_ready;
    hold_w <= {wr_addr, wr_data};
  end

  function automatic wr_t make_wr(input int row, input int col, input logic [31:0] data);
    wr_t w;
    w.addr = 16'(m_base + (row * m_width + col) * m_groups + m_group);
    w.data = data;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    wr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic clear_lanes();
    in_valid = '0;
    in_row   = '0;
    in_col   = '0;
    in_data  = '0;
  endtask

  task automatic drive_lane(input int ch, input int row, input int col, input logic [7:0] d);
    in_valid[ch] = 1'b1;
    in_row[ch]   = 4'(row);
    in_col[ch]   = 4'(col);
    in_data[ch]  = d;
  endtask

  task automatic configure(input int base, input int width, input int groups, input int grp,
                           input int num);
    m_base = base; m_width = width; m_groups = groups; m_group = grp;
    cfg_base = 16'(base); cfg_width = 5'(width); cfg_groups = 8'(groups);
    cfg_group = 8'(grp); cfg_num_pixels = 9'(num);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) step();
    repeat (3) step();
    check(tag, got_q.size(), n);
  endtask

  task automatic compare_writes(input string tag);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      wr_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_addr"}, g.addr, e.addr);
      check({tag, "_data"}, g.data, e.data);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_random_pass(input int pass);
    int g, dc0, best;
    int prow[4], pcol[4], slot[4][4], alloc_c[4], alloc_l[4], comp_c[4], idx[4];
    int busy_until[4];
    bit pushed[4];
    logic [31:0] pdata[4];
    logic [7:0] used;
    g = $urandom_range(1, 4);
    for (int p = 0; p < g; p++) begin
      bit clash;
      do begin
        prow[p] = $urandom_range(0, 15);
        pcol[p] = $urandom_range(0, 15);
        clash = 1'b0;
        for (int q = 0; q < p; q++) if (prow[q] == prow[p] && pcol[q] == pcol[p]) clash = 1'b1;
      end while (clash);
      pdata[p] = $urandom;
    end
    for (int ch = 0; ch < 4; ch++) begin
      used = '0;
      for (int p = 0; p < g; p++) begin
        int c;
        do c = $urandom_range(0, 7); while (used[c]);
        used[c] = 1'b1;
        slot[p][ch] = c;
      end
    end
    begin
      int grps;
      grps = $urandom_range(1, 8);
      dc0 = done_cnt;
      configure($urandom_range(0, 65535), $urandom_range(1, 16), grps,
                $urandom_range(0, grps - 1), g);
    end
    for (int c = 0; c < 8; c++) begin
      clear_lanes();
      for (int ch = 0; ch < 4; ch++)
        for (int p = 0; p < g; p++)
          if (slot[p][ch] == c) drive_lane(ch, prow[p], pcol[p], pdata[p][8*ch +: 8]);
      step();
    end
    clear_lanes();
    // Model: first byte allocates the lowest free entry; each cycle the lowest
    // entry holding a complete pixel (completed in an earlier cycle) is written out.
    for (int p = 0; p < g; p++) begin
      alloc_c[p] = 99; alloc_l[p] = 0; comp_c[p] = -1; idx[p] = -1; pushed[p] = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        if (slot[p][ch] < alloc_c[p]) begin alloc_c[p] = slot[p][ch]; alloc_l[p] = ch; end
        if (slot[p][ch] > comp_c[p]) comp_c[p] = slot[p][ch];
      end
    end
    for (int i = 0; i < 4; i++) busy_until[i] = 0;
    for (int t = 0; t < 40; t++) begin
      best = -1;
      for (int p = 0; p < g; p++)
        if (!pushed[p] && idx[p] >= 0 && comp_c[p] < t && (best < 0 || idx[p] < idx[best]))
          best = p;
      if (best >= 0) begin
        pushed[best] = 1'b1;
        busy_until[idx[best]] = t + 1;
        exp_q.push_back(make_wr(prow[best], pcol[best], pdata[best]));
      end
      for (int ch = 0; ch < 4; ch++)
        for (int p = 0; p < g; p++)
          if (alloc_c[p] == t && alloc_l[p] == ch)
            for (int i = 0; i < 4; i++)
              if (idx[p] < 0 && t >= busy_until[i]) begin idx[p] = i; busy_until[i] = 1000; end
    end
    wait_writes($sformatf("rnd%0d_count", pass), g, 300);
    compare_writes($sformatf("rnd%0d", pass));
    check($sformatf("rnd%0d_done", pass), done_cnt - dc0, 1);
    check($sformatf("rnd%0d_errs", pass), {overflow_err, dup_err}, 0);
    check($sformatf("rnd%0d_busy", pass), busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    int dc0;
    logic [31:0] d;
    reset_n = 1'b1; cfg_valid = 1'b0; cfg_base = '0; cfg_width = '0; cfg_groups = '0;
    cfg_group = '0; cfg_num_pixels = '0; wr_ready = 1'b1;
    clear_lanes();
    #1 reset_n = 1'b0;
    step();
    check("rst_outputs", {wr_valid, wr_addr, wr_data, busy, done, overflow_err, dup_err}, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single pixel, all lanes in one cycle.
    rdy_mode = 0;
    configure(16'h100, 4, 2, 1, 1);
    for (int ch = 0; ch < 4; ch++) drive_lane(ch, 2, 3, 8'(17 * (ch + 1)));
    step();
    clear_lanes();
    @(negedge clk); check("t1_valid_early", wr_valid, 0);
    step();
    @(negedge clk);
    check("t1_valid", wr_valid, 1);
    check("t1_addr", wr_addr, 16'h117);
    check("t1_data", wr_data, 32'h44332211);
    step(); @(negedge clk); check("t1_done", done, 1);
    step(); @(negedge clk); check("t1_done_width", done, 0); check("t1_busy", busy, 0);
    got_q.delete();

    // Lanes of (0,0) spread over cycles 0,3,1,5.
    configure(16'h200, 8, 1, 0, 1);
    d = 32'hA4A3A2A1;
    for (int c = 0; c < 6; c++) begin
      clear_lanes();
      if (c == 0) drive_lane(0, 0, 0, d[7:0]);
      if (c == 1) drive_lane(2, 0, 0, d[23:16]);
      if (c == 3) drive_lane(1, 0, 0, d[15:8]);
      if (c == 5) drive_lane(3, 0, 0, d[31:24]);
      step();
    end
    clear_lanes();
    @(negedge clk); check("t2_valid_early", wr_valid, 0);
    step(); @(negedge clk); check("t2_valid", wr_valid, 1);
    exp_q.push_back(make_wr(0, 0, d));
    wait_writes("t2_count", 1, 20);
    compare_writes("t2");
    check("t2_errs", {overflow_err, dup_err}, 0);

    // Five incomplete tags with four table entries.
    configure(16'h300, 16, 1, 0, 4);
    for (int k = 0; k < 5; k++) begin
      clear_lanes(); drive_lane(0, 0, k + 1, 8'(k + 1)); step();
    end
    clear_lanes();
    @(negedge clk); check("t3_ovf", overflow_err, 1); check("t3_dup", dup_err, 0);
    dc0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      d = $urandom; d[7:0] = 8'(k + 1);
      clear_lanes();
      for (int ch = 1; ch < 4; ch++) drive_lane(ch, 0, k + 1, d[8*ch +: 8]);
      exp_q.push_back(make_wr(0, k + 1, d));
      step();
    end
    clear_lanes();
    wait_writes("t3_count", 4, 50);
    compare_writes("t3");
    check("t3_done", done_cnt - dc0, 1);
    check("t3_ovf_sticky", overflow_err, 1);

    // Stall the write port while eight pixels complete.
    rdy_mode = 2;
    configure(16'h400, 16, 2, 1, 8);
    for (int p = 0; p < 8; p++) begin
      d = $urandom;
      clear_lanes();
      for (int ch = 0; ch < 4; ch++) drive_lane(ch, p + 1, p, d[8*ch +: 8]);
      exp_q.push_back(make_wr(p + 1, p, d));
      step();
    end
    clear_lanes(); drive_lane(0, 15, 15, 8'h5A); step(); clear_lanes();
    @(negedge clk);
    check("t4_ovf", overflow_err, 1);
    check("t4_valid", wr_valid, 1);
    check("t4_no_writes", got_q.size(), 0);
    repeat (11) step();
    rdy_mode = 0;
    wait_writes("t4_count", 8, 100);
    compare_writes("t4");

    // Duplicate lane byte, then an empty pass.
    configure(16'h500, 4, 1, 0, 1);
    d = 32'h44BB2211;
    drive_lane(2, 1, 1, 8'hAA); step();
    clear_lanes(); drive_lane(2, 1, 1, 8'hBB); step();
    clear_lanes();
    for (int ch = 0; ch < 4; ch++) if (ch != 2) drive_lane(ch, 1, 1, d[8*ch +: 8]);
    @(negedge clk); check("t5_dup", dup_err, 1); check("t5_ovf_cleared", overflow_err, 0);
    exp_q.push_back(make_wr(1, 1, d));
    step(); clear_lanes();
    wait_writes("t5_count", 1, 20);
    compare_writes("t5");
    dc0 = done_cnt;
    configure(16'h600, 4, 1, 0, 0);
    repeat (4) step();
    check("t5_empty_done", done_cnt - dc0, 1);
    check("t5_empty_writes", got_q.size(), 0);
    check("t5_dup_cleared", dup_err, 0);

    // Reset while a pass holds pending entries and a queued word.
    rdy_mode = 2;
    configure(16'h700, 4, 1, 0, 4);
    for (int ch = 0; ch < 4; ch++) drive_lane(ch, 3, 3, 8'(ch + 1));
    step(); clear_lanes(); drive_lane(0, 4, 4, 8'h01);
    step(); clear_lanes(); drive_lane(1, 5, 5, 8'h02);
    step(); clear_lanes();
    repeat (3) step();
    check("t6_pre_valid", wr_valid, 1);
    #2 reset_n = 1'b0;
    #1 check("t6_rst_outputs",
             {wr_valid, wr_addr, wr_data, busy, done, overflow_err, dup_err}, 0);
    step(); reset_n = 1'b1;
    rdy_mode = 0;
    step();
    got_q.delete();
    configure(16'h800, 4, 1, 0, 1);
    d = $urandom;
    for (int ch = 0; ch < 4; ch++) drive_lane(ch, 2, 2, d[8*ch +: 8]);
    exp_q.push_back(make_wr(2, 2, d));
    step(); clear_lanes();
    wait_writes("t6_count", 1, 30);
    compare_writes("t6");

    rdy_mode = 1;
    for (int pass = 0; pass < 10; pass++) run_random_pass(pass);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
